// File: rtl/flash_emu_pkg.sv
// ============================================================================
// Module  : flash_emu_pkg
// Purpose : Shared constants and types for the 256x8 parallel NOR flash
//           emulator: FSM state encodings, erased-byte value, erase command
//           bytes/address, busy-counter width and the boot-block protection
//           helper.
// Macros  : FLASH_EMU_ERASE_EN (consumed by flash_emu, constants always here)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package flash_emu_pkg;

  // Write-cycle FSM encodings
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_WR_LOW = 2'd1;
  localparam logic [1:0] c_ST_BUSY   = 2'd2;

  // Device constants
  localparam logic [7:0] c_ERASED        = 8'hFF;
  localparam logic [7:0] c_CMD_ERASE     = 8'h20;
  localparam logic [7:0] c_CMD_CONFIRM   = 8'hD0;
  localparam logic [7:0] c_ERASE_ADDR    = 8'hFF;

  // Busy counter holds up to 4*255 cycles (erase of the largest PROG_CYCLES)
  localparam int c_CNT_W = 10;

  // Address/data pair captured during the WE#-low phase of a write
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_req_t;

  // Boot block 0..last is write-protected while WP# is low
  function automatic logic addr_protected(input logic [7:0] addr,
                                          input logic       wp,
                                          input logic [7:0] last);
    return (!wp) && (addr <= last);
  endfunction

endpackage

`default_nettype wire

// File: rtl/flash_emu_if.sv
// ============================================================================
// Module  : flash_emu_if
// Purpose : Pin bundle between the flash bridge (master) and the flash
//           emulator (slave). The bidirectional data bus stays a plain port
//           on the emulator so it can be resolved as a real tri-state net.
// Signals : NF_CE/NF_OE/NF_WE  active-low strobes (master -> slave)
//           NF_WP              0 = boot block protected (master -> slave)
//           NF_A[7:0]          byte address (master -> slave)
//           NF_STS             1 = ready, 0 = busy (slave -> master)
//           wr_err             sticky rejected-write flag (slave -> master)
//           prog_cnt[7:0]      committed program count (slave -> master)
// Macros  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface flash_emu_if;
  logic       NF_CE;
  logic       NF_OE;
  logic       NF_WE;
  logic       NF_WP;
  logic [7:0] NF_A;
  logic       NF_STS;
  logic       wr_err;
  logic [7:0] prog_cnt;

  modport master (
    output NF_CE, NF_OE, NF_WE, NF_WP, NF_A,
    input  NF_STS, wr_err, prog_cnt
  );

  modport slave (
    input  NF_CE, NF_OE, NF_WE, NF_WP, NF_A,
    output NF_STS, wr_err, prog_cnt
  );
endinterface

`default_nettype wire

// File: rtl/flash_emu_mem.sv
// ============================================================================
// Module  : flash_emu_mem
// Purpose : 256x8 flash array. One synchronous read port, one
//           read-modify-write program port (bits can only be cleared) and a
//           whole-array erase input that can spare the boot block.
//           Cells are stored inverted so a zero-initialised array (BRAM
//           power-up state) reads back as erased 8'hFF.
// Ports   : clk                 clock
//           rd_addr / rd_data   sync read, one clock latency
//           pg_en/pg_addr/pg_data  program: cell <= cell & pg_data
//           er_en               erase all cells to 8'hFF
//           er_keep_boot        when set, erase skips 0..boot_last
//           boot_last           last address of the boot block
// Macros  : none (erase port is tied off by the top when not built in)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_emu_mem
  import flash_emu_pkg::*;
(
  input  wire        clk,
  input  wire  [7:0] rd_addr,
  output logic [7:0] rd_data,
  input  wire        pg_en,
  input  wire  [7:0] pg_addr,
  input  wire  [7:0] pg_data,
  input  wire        er_en,
  input  wire        er_keep_boot,
  input  wire  [7:0] boot_last
);

  // Inverted storage: a stored 1 means the bit has been programmed to 0
  logic [7:0] r_cells_n [0:255];

  // Array contents are deliberately not reset: a device reset must not
  // lose programmed data.
  always_ff @(posedge clk) begin
    rd_data <= ~r_cells_n[rd_addr];
    if (er_en) begin
      for (int i = 0; i < 256; i++) begin
        if (!(er_keep_boot && (8'(i) <= boot_last))) begin
          r_cells_n[i] <= ~c_ERASED;
        end
      end
    end else if (pg_en) begin
      // AND semantics on the visible value == OR on the inverted cell
      r_cells_n[pg_addr] <= r_cells_n[pg_addr] | ~pg_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/flash_emu.sv
// ============================================================================
// Module  : flash_emu
// Purpose : Synthesizable responder for an 8-bit parallel NOR flash pin
//           interface. Emulates a 256x8 device with CE#/OE#/WE# strobes
//           sampled on CLK_50MHZ, program-only-clears-bits semantics, boot
//           block protection and a busy period reported on NF_STS.
// Params  : PROG_CYCLES  busy cycles after a program commit (1..255)
//           PROT_LAST    last address of the protected boot block
// Ports   : CLK_50MHZ    system clock
//           RST_N        asynchronous active-low reset
//           bus          flash_emu_if.slave (strobes, WP#, address, status)
//           NF_D[7:0]    data, driven only in the read window, else Z
// Macros  : FLASH_EMU_ERASE_EN - when defined, the two-write sequence
//           8'h20 then 8'hD0 to address 8'hFF erases the array (busy for
//           4*PROG_CYCLES, boot block kept while WP#=0). When undefined both
//           writes are ordinary programs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_emu
  import flash_emu_pkg::*;
#(
  parameter int         PROG_CYCLES = 50,
  parameter logic [7:0] PROT_LAST   = 8'h0F
) (
  input  wire       CLK_50MHZ,
  input  wire       RST_N,
  flash_emu_if.slave bus,
  inout  wire [7:0] NF_D
);

  localparam logic [c_CNT_W-1:0] c_PROG_LOAD  = c_CNT_W'(PROG_CYCLES);
  localparam logic [c_CNT_W-1:0] c_ERASE_LOAD = c_CNT_W'(4 * PROG_CYCLES);

  // --------------------------------------------------------------------------
  // Input sampling: every decision below uses these registered copies
  // --------------------------------------------------------------------------
  logic       r_ce;
  logic       r_oe;
  logic       r_we;
  logic       r_ce_prev;
  logic [7:0] r_a;
  logic [7:0] r_d;

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_ce      <= 1'b1;
      r_oe      <= 1'b1;
      r_we      <= 1'b1;
      r_ce_prev <= 1'b1;
      r_a       <= 8'h00;
      r_d       <= 8'h00;
    end else begin
      r_ce      <= bus.NF_CE;
      r_oe      <= bus.NF_OE;
      r_we      <= bus.NF_WE;
      r_ce_prev <= r_ce;
      r_a       <= bus.NF_A;
      r_d       <= NF_D;
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  wr_req_t            r_wr;
  logic               r_wr_err;
  logic [7:0]         r_prog_cnt;
  logic               r_rd_oe;

  logic               w_wr_low;
  logic               w_commit;
  logic               w_abort;
  logic               w_prot;
  logic               w_is_setup;
  logic               w_is_confirm;
  logic               w_pg_en;
  logic               w_er_en;
  logic [7:0]         w_rd_data;

  // Both strobes low: a write cycle is in its low phase
  assign w_wr_low = !r_ce && !r_we;

  // WE-controlled commit (WE rises with CE low on the previous sample) or
  // CE-controlled commit (CE rises while WE is still low).
  assign w_commit = (r_state == c_ST_WR_LOW) &&
                    ((!r_we && r_ce) || (r_we && !r_ce_prev));
  assign w_abort  = (r_state == c_ST_WR_LOW) && r_we && r_ce_prev;

  assign w_prot   = addr_protected(r_wr.addr, bus.NF_WP, PROT_LAST);

`ifdef FLASH_EMU_ERASE_EN
  logic r_armed;

  assign w_is_setup   = (r_wr.addr == c_ERASE_ADDR) && (r_wr.data == c_CMD_ERASE);
  assign w_is_confirm = r_armed && (r_wr.addr == c_ERASE_ADDR) &&
                        (r_wr.data == c_CMD_CONFIRM);

  // The setup command is armed only by the very next write; any commit
  // attempt (accepted or rejected) consumes it.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_armed <= 1'b0;
    end else if (w_commit) begin
      r_armed <= w_is_setup && !w_prot;
    end
  end
`else
  assign w_is_setup   = 1'b0;
  assign w_is_confirm = 1'b0;
`endif

  assign w_pg_en = w_commit && !w_prot && !w_is_confirm && !w_is_setup;
  assign w_er_en = w_commit && !w_prot && w_is_confirm;

  // --------------------------------------------------------------------------
  // Write-cycle FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= c_ST_IDLE;
      r_cnt      <= '0;
      r_wr       <= '0;
      r_wr_err   <= 1'b0;
      r_prog_cnt <= 8'h00;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_wr_low) begin
            r_state <= c_ST_WR_LOW;
            r_wr    <= '{addr: r_a, data: r_d};
          end
        end

        c_ST_WR_LOW: begin
          if (w_commit) begin
            if (w_prot) begin
              r_wr_err <= 1'b1;
              r_state  <= c_ST_IDLE;
            end else if (w_is_confirm) begin
              r_cnt   <= c_ERASE_LOAD;
              r_state <= c_ST_BUSY;
            end else if (w_is_setup) begin
              r_state <= c_ST_IDLE;
            end else begin
              r_prog_cnt <= r_prog_cnt + 8'd1;
              r_cnt      <= c_PROG_LOAD;
              r_state    <= c_ST_BUSY;
            end
          end else if (w_abort) begin
            r_state <= c_ST_IDLE;
          end else if (w_wr_low) begin
            // Last address/data seen during the low phase wins
            r_wr <= '{addr: r_a, data: r_d};
          end
        end

        c_ST_BUSY: begin
          if (w_wr_low) begin
            r_wr_err <= 1'b1;
          end
          // STS rises as the count reaches zero; FSM leaves one clock later
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= c_ST_IDLE;
          end
        end

        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read path: window decided on sampled strobes, data from the registered
  // array port, so both line up two clocks after OE# falls. A write strobe
  // blocks the driver to avoid contention with the bridge.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_oe <= 1'b0;
    end else begin
      r_rd_oe <= !r_ce && !r_oe && r_we;
    end
  end

  flash_emu_mem u_mem (
    .clk          (CLK_50MHZ),
    .rd_addr      (r_a),
    .rd_data      (w_rd_data),
    .pg_en        (w_pg_en),
    .pg_addr      (r_wr.addr),
    .pg_data      (r_wr.data),
    .er_en        (w_er_en),
    .er_keep_boot (!bus.NF_WP),
    .boot_last    (PROT_LAST)
  );

  assign NF_D = r_rd_oe ? w_rd_data : 8'bz;

  // Status is derived from state so an async reset raises it immediately
  assign bus.NF_STS   = !((r_state == c_ST_BUSY) && (r_cnt != '0));
  assign bus.wr_err   = r_wr_err;
  assign bus.prog_cnt = r_prog_cnt;

endmodule

`default_nettype wire

// File: tb/tb_flash_emu.sv
// ============================================================================
// Module  : tb_flash_emu
// Purpose : Self-checking bench for flash_emu. Read results are checked via
//           an expected-value queue; status/counters checked directly.
// Macros  : FLASH_EMU_ERASE_EN enables the erase-sequence scenario
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flash_emu;

  logic       clk;
  logic       rst_n;
  logic       tb_drv;
  logic [7:0] tb_d;
  wire  [7:0] nf_d;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  flash_emu_if bus ();

  assign nf_d = tb_drv ? tb_d : 8'bz;

  // Undriven bus reads as 8'h00 so a released bus is distinguishable from
  // erased data
  for (genvar i = 0; i < 8; i++) begin : g_pd
    pulldown (nf_d[i]);
  end

  flash_emu #(
    .PROG_CYCLES (50),
    .PROT_LAST   (8'h0F)
  ) dut (
    .CLK_50MHZ (clk),
    .RST_N     (rst_n),
    .bus       (bus),
    .NF_D      (nf_d)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the bus released
  task automatic flash_read(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    exp_q.push_back(exp);
    bus.NF_A  = addr;
    bus.NF_CE = 1'b0;
    bus.NF_OE = 1'b0;
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    check(tag, nf_d, e);
    bus.NF_CE = 1'b1;
    bus.NF_OE = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // WE-controlled write; returns one negedge before the commit clock
  task automatic flash_write(input logic [7:0] addr, input logic [7:0] data);
    bus.NF_A  = addr;
    tb_d      = data;
    tb_drv    = 1'b1;
    bus.NF_CE = 1'b0;
    bus.NF_WE = 1'b0;
    repeat (3) @(negedge clk);
    bus.NF_WE = 1'b1;
    @(negedge clk);
    bus.NF_CE = 1'b1;
    tb_drv    = 1'b0;
  endtask

  // Counts negedges with STS low, starting just after the commit clock
  task automatic wait_ready(output int n);
    int guard;
    n     = 0;
    guard = 0;
    @(negedge clk);
    while (bus.NF_STS == 1'b0 && guard < 2000) begin
      n++;
      guard++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    tb_drv    = 1'b0;
    tb_d      = 8'h00;
    bus.NF_CE = 1'b1;
    bus.NF_OE = 1'b1;
    bus.NF_WE = 1'b1;
    bus.NF_WP = 1'b1;
    bus.NF_A  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: reset state and erased read with latency
    check("t1_sts",      bus.NF_STS,   1);
    check("t1_wr_err",   bus.wr_err,   0);
    check("t1_prog_cnt", bus.prog_cnt, 0);
    check("t1_hiz_idle", nf_d,         8'h00);
    exp_q.push_back(8'hFF);
    bus.NF_A  = 8'h05;
    bus.NF_CE = 1'b0;
    bus.NF_OE = 1'b0;
    @(negedge clk);
    check("t1_not_yet", nf_d, 8'h00);
    @(negedge clk);
    check("t1_rd05", nf_d, exp_q.pop_front());
    bus.NF_CE = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_hiz_ce", nf_d, 8'h00);
    bus.NF_OE = 1'b1;

    // T2: program, busy length, readback
    flash_write(8'h30, 8'hA5);
    wait_ready(n);
    check("t2_busy_len", n, 50);
    check("t2_prog_cnt", bus.prog_cnt, 1);
    flash_read(8'h30, 8'hA5, "t2_rd30");

    // T3: AND semantics
    flash_write(8'h30, 8'h5A);
    wait_ready(n);
    check("t3_busy_len", n, 50);
    flash_read(8'h30, 8'h00, "t3_rd30");
    check("t3_prog_cnt", bus.prog_cnt, 2);
    check("t3_wr_err",   bus.wr_err,   0);

    // T4: protected boot block, and first unprotected address
    bus.NF_WP = 1'b0;
    flash_write(8'h03, 8'h00);
    @(negedge clk);
    check("t4_sts",      bus.NF_STS, 1);
    check("t4_wr_err",   bus.wr_err, 1);
    @(negedge clk);
    flash_read(8'h03, 8'hFF, "t4_rd03");
    check("t4_prog_cnt", bus.prog_cnt, 2);
    flash_write(8'h10, 8'h3C);
    wait_ready(n);
    check("t4_busy_len", n, 50);
    flash_read(8'h10, 8'h3C, "t4_rd10");
    check("t4_prog_cnt3", bus.prog_cnt, 3);

    // T5: reset keeps memory; write during busy; reset mid-busy
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.NF_WP = 1'b1;
    @(negedge clk);
    check("t5_rst_wr_err", bus.wr_err,   0);
    check("t5_rst_cnt",    bus.prog_cnt, 0);
    flash_read(8'h10, 8'h3C, "t5_keep10");
    flash_write(8'h50, 8'h0F);
    flash_read(8'h50, 8'h0F, "t5_rd_busy");
    flash_write(8'h60, 8'h00);
    wait_ready(n);
    check("t5_busy_wr_err", bus.wr_err,   1);
    check("t5_prog_cnt",    bus.prog_cnt, 1);
    @(negedge clk);
    flash_read(8'h60, 8'hFF, "t5_rd60");
    flash_write(8'h70, 8'h77);
    repeat (10) @(negedge clk);
    check("t5_mid_busy", bus.NF_STS, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_sts", bus.NF_STS, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_rst_cnt2", bus.prog_cnt, 0);
    flash_read(8'h70, 8'h77, "t5_rd70");

`ifdef FLASH_EMU_ERASE_EN
    // T6: erase sequence
    flash_write(8'hFF, 8'h20);
    @(negedge clk);
    check("t6_setup_sts", bus.NF_STS, 1);
    @(negedge clk);
    flash_write(8'hFF, 8'hD0);
    wait_ready(n);
    check("t6_busy_len",  n, 200);
    check("t6_prog_cnt",  bus.prog_cnt, 0);
    @(negedge clk);
    flash_read(8'h30, 8'hFF, "t6_rd30");
    flash_read(8'h70, 8'hFF, "t6_rd70");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
